// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: reset requests and cause clear in, sequenced resets,
// ready and sticky cause flags out.
// Optional macro RESET_SEQ_PLL_LOCK_EN adds pll_locked and a loss-of-lock cause bit.
interface reset_sequencer_if #(
    parameter int N_OUT = 2,
    parameter int N_SRC = 2
);
`ifdef RESET_SEQ_PLL_LOCK_EN
    localparam int CAUSE_W = N_SRC + 2;
`else
    localparam int CAUSE_W = N_SRC + 1;
`endif

    logic [N_SRC-1:0]   rst_req;
    logic               cause_clr;
`ifdef RESET_SEQ_PLL_LOCK_EN
    logic               pll_locked;
`endif
    logic [N_OUT-1:0]   rst_out;
    logic               ready;
    logic [CAUSE_W-1:0] rst_cause;

`ifdef RESET_SEQ_PLL_LOCK_EN
    modport master (output rst_req, cause_clr, pll_locked,
                    input  rst_out, ready, rst_cause);
    modport slave  (input  rst_req, cause_clr, pll_locked,
                    output rst_out, ready, rst_cause);
`else
    modport master (output rst_req, cause_clr,
                    input  rst_out, ready, rst_cause);
    modport slave  (input  rst_req, cause_clr,
                    output rst_out, ready, rst_cause);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: merges board reset with internal reset requests, stretches
// the merged reset, then releases N_OUT domains one at a time with a fixed
// stagger. Keeps sticky cause flags for software.
// Optional macro RESET_SEQ_PLL_LOCK_EN: loss of PLL lock acts as one more
// reset source and gets its own cause bit (top bit).
module reset_sequencer #(
    parameter int N_OUT       = 2,
    parameter int N_SRC       = 2,
    parameter int CNT_W       = 16,
    parameter int STRETCH_CYC = 65535,
    parameter int STAGGER_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    reset_sequencer_if.slave bus
);
`ifdef RESET_SEQ_PLL_LOCK_EN
    localparam int CAUSE_W = N_SRC + 2;
`else
    localparam int CAUSE_W = N_SRC + 1;
`endif
    // idx has to reach N_OUT after the last release, hence N_OUT+1
    localparam int IDX_W = $clog2(N_OUT + 1);
    localparam logic [CNT_W-1:0] STRETCH_V = CNT_W'(STRETCH_CYC);
    localparam logic [CNT_W-1:0] STAGGER_V = CNT_W'(STAGGER_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {HOLD, STRETCH, RELEASE, RUN} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_OUT-1:0]   rst_out_q, rst_out_d;
    logic               ready_q, ready_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               src_act;
    logic [CAUSE_W-1:0] cause_set;

    // Merge all reset sources; the same vector feeds the sticky cause flags
    always_comb begin
`ifdef RESET_SEQ_PLL_LOCK_EN
        src_act   = reset | (|bus.rst_req) | ~bus.pll_locked;
        cause_set = {~bus.pll_locked, bus.rst_req, reset};
`else
        src_act   = reset | (|bus.rst_req);
        cause_set = {bus.rst_req, reset};
`endif
    end

    // Next-state logic: any active source aborts to HOLD, otherwise walk
    // STRETCH -> RELEASE -> RUN using one saturating counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // set wins over clear so a request on the clearing edge is not lost
        cause_d   = (bus.cause_clr ? '0 : cause_q) | cause_set;

        if (src_act) begin
            state_d   = HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = STRETCH;
                    cnt_d   = CNT_W'(1);
                end
                STRETCH: begin
                    if (cnt_q == STRETCH_V) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = CNT_W'(1);
                        idx_d        = IDX_W'(1);
                        if (N_OUT == 1) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGGER_V) begin
                        for (int k = 0; k < N_OUT; k++) begin
                            if (IDX_W'(k) == idx_q) rst_out_d[k] = 1'b0;
                        end
                        cnt_d = CNT_W'(1);
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                RUN: begin
                    rst_out_d = '0;
                    ready_d   = 1'b1;
                end
                default: state_d = HOLD;
            endcase
        end
    end

    // All state and outputs registered; board reset forces the hold state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            cause_q   <= CAUSE_W'(1);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            cause_q   <= cause_d;
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;
`ifdef RESET_SEQ_PLL_LOCK_EN
  localparam int CW = 4;
`else
  localparam int CW = 3;
`endif

  typedef struct {
    int             cyc;
    string          name;
    logic [2:0]     ro;
    logic           rdy;
    logic [CW-1:0]  cz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  reset_sequencer_if #(.N_OUT(3), .N_SRC(2)) bus();

  reset_sequencer #(
    .N_OUT(3), .N_SRC(2), .CNT_W(4), .STRETCH_CYC(8), .STAGGER_CYC(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc < cyc) begin
          failures++;
          $display("FAIL %s expired: scheduled cyc=%0d, checked at cyc=%0d",
                   q[i].name, q[i].cyc, cyc);
        end else if (bus.rst_out !== q[i].ro || bus.ready !== q[i].rdy ||
                     bus.rst_cause !== q[i].cz) begin
          failures++;
          $display("FAIL %s cyc=%0d got ro=%b rdy=%b cause=%b exp ro=%b rdy=%b cause=%b",
                   q[i].name, cyc, bus.rst_out, bus.ready, bus.rst_cause,
                   q[i].ro, q[i].rdy, q[i].cz);
        end
        q.delete(i);
      end
    end
  end

  task automatic push(input int c, input string nm, input logic [2:0] ro,
                      input logic rdy, input logic [CW-1:0] cz);
    exp_t e;
    e.cyc = c; e.name = nm; e.ro = ro; e.rdy = rdy; e.cz = cz;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic run_seq(input int e0, input logic [CW-1:0] cz);
    push(e0,      "seq_e0",   3'b111, 1'b0, cz);
    push(e0 + 7,  "pre_rel0", 3'b111, 1'b0, cz);
    push(e0 + 8,  "rel0",     3'b110, 1'b0, cz);
    push(e0 + 11, "pre_rel1", 3'b110, 1'b0, cz);
    push(e0 + 12, "rel1",     3'b100, 1'b0, cz);
    push(e0 + 15, "pre_rel2", 3'b100, 1'b0, cz);
    push(e0 + 16, "rel2_rdy", 3'b000, 1'b1, cz);
    push(e0 + 20, "run_hold", 3'b000, 1'b1, cz);
    wait_until(e0 + 21);
  endtask

  initial begin
    int s;
    int e0;
    bus.rst_req   = '0;
    bus.cause_clr = 1'b0;
`ifdef RESET_SEQ_PLL_LOCK_EN
    bus.pll_locked = 1'b1;
`endif
    push(2, "reset_state", 3'b111, 1'b0, CW'(3'b001));
    push(5, "reset_state5", 3'b111, 1'b0, CW'(3'b001));
    repeat (5) @(negedge clk);
    reset = 1'b0;
    run_seq(cyc + 1, CW'(3'b001));

    s = cyc;
    bus.rst_req = 2'b10;
    push(s + 1, "req1_abort", 3'b111, 1'b0, CW'(3'b101));
    @(negedge clk);
    bus.rst_req = 2'b00;
    run_seq(s + 2, CW'(3'b101));

    s = cyc;
    bus.rst_req = 2'b01;
    push(s + 1, "req0_hold", 3'b111, 1'b0, CW'(3'b111));
    @(negedge clk);
    bus.rst_req = 2'b00;
    e0 = s + 2;
    push(e0 + 9, "mid_rel0", 3'b110, 1'b0, CW'(3'b111));
    push(e0 + 10, "mid_abort", 3'b111, 1'b0, CW'(3'b111));
    wait_until(e0 + 9);
    bus.rst_req = 2'b01;
    @(negedge clk);
    bus.rst_req = 2'b00;
    run_seq(e0 + 11, CW'(3'b111));

    s = cyc;
    bus.cause_clr = 1'b1;
    push(s + 1, "clr_only", 3'b000, 1'b1, CW'(3'b000));
    @(negedge clk);
    bus.cause_clr = 1'b0;
    reset = 1'b1;
    push(s + 2, "reset_pulse", 3'b111, 1'b0, CW'(3'b001));
    @(negedge clk);
    reset = 1'b0;
    bus.rst_req = 2'b10;
    push(s + 3, "cause_101", 3'b111, 1'b0, CW'(3'b101));
    @(negedge clk);
    bus.rst_req = 2'b01;
    bus.cause_clr = 1'b1;
    push(s + 4, "clr_set_wins", 3'b111, 1'b0, CW'(3'b010));
    @(negedge clk);
    bus.rst_req = 2'b00;
    bus.cause_clr = 1'b0;
    run_seq(s + 5, CW'(3'b010));

    s = cyc;
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) push(s + k, "long_reset", 3'b111, 1'b0, CW'(3'b001));
    repeat (5) @(negedge clk);
    bus.cause_clr = 1'b1;
    @(negedge clk);
    bus.cause_clr = 1'b0;
    wait_until(s + 20);
    reset = 1'b0;
    run_seq(s + 21, CW'(3'b001));

`ifdef RESET_SEQ_PLL_LOCK_EN
    s = cyc;
    bus.pll_locked = 1'b0;
    push(s + 1, "lock_loss", 3'b111, 1'b0, 4'b1001);
    @(negedge clk);
    bus.pll_locked = 1'b1;
    run_seq(s + 2, 4'b1001);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending: %0d expectations never checked", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-counter power-on reset stretcher used in the FPGA top wrappers.
- Merges an external reset with N_SRC internal reset requests, such as a CPU soft reset or a watchdog.
- Stretches the merged reset, then releases N_OUT reset domains one at a time with a programmable stagger.
- Latches the reset cause for software and sits between board reset logic and the system/peripheral reset inputs.

Parameters:
- N_OUT, 2: number of sequenced reset outputs, 1..8.
- N_SRC, 2: number of internal reset request inputs, 1..8.
- CNT_W, 16: counter width.
- STRETCH_CYC, 65535: cycles from all sources quiet to release of rst_out[0]; 1..2^CNT_W-1.
- STAGGER_CYC, 16: cycles between release of rst_out[k-1] and rst_out[k]; 1..2^CNT_W-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; external/board reset, already synchronised to clk.
- rst_req  in  N_SRC  active-high reset requests; a 1-cycle pulse suffices.
- cause_clr  in  1  1-cycle pulse; clears rst_cause.
- rst_out  out  N_OUT  active-high reset per domain; bit 0 released first.
- ready  out  1  high when all rst_out are released.
- rst_cause  out  N_SRC+1  sticky cause flags; bit0 = reset, bit i+1 = rst_req[i].

Behaviour:
- One clock, clk. Reset is synchronous and active-high; no other reset input.
- All outputs are registered.
- src_act = reset | (|rst_req) [| ~pll_locked, see Optional Feature].
- Reset values (reset high at an edge):
  - state=HOLD, cnt=0, idx=0.
  - rst_out = all ones, ready=0.
  - rst_cause = {N_SRC'b0, 1'b1}.
- States:
  - HOLD:
    - rst_out all 1, ready 0, cnt=0.
    - If src_act is low at an edge -> STRETCH, cnt=1.
  - STRETCH:
    - cnt increments each edge.
    - At the edge where cnt==STRETCH_CYC: rst_out[0] <= 0, cnt <= 1, idx <= 1; go to RELEASE, or to RUN if N_OUT==1.
  - RELEASE:
    - cnt increments each edge.
    - At the edge where cnt==STAGGER_CYC: rst_out[idx] <= 0, cnt <= 1, idx <= idx+1.
    - When idx==N_OUT-1 is released -> RUN.
  - RUN:
    - rst_out all 0, ready 1.
- Timing:
  - Define edge E0 as the first edge with src_act sampled low.
  - rst_out[0] falls at E0+STRETCH_CYC.
  - rst_out[k] falls at E0+STRETCH_CYC+k*STAGGER_CYC.
  - ready rises on the same edge as rst_out[N_OUT-1] falls.
- Abort: src_act high at any edge in any state -> next state HOLD.
  - All rst_out <= 1, ready <= 0, cnt <= 0, idx <= 0, on that same edge.
  - The sequence restarts in full once src_act clears; there is no partial resume.
- Counter arithmetic: cnt is CNT_W bits and never wraps. It saturates; compares are exact equality.
- rst_cause:
  - Bit i+1 is set on any edge with rst_req[i]=1.
  - Bit 0 is set on any edge with reset=1.
  - cause_clr=1 clears all bits, except those being set on that same edge (set wins).
  - rst_cause is not cleared by its own sequence, so software reads it after release.
- Simultaneous requests set every corresponding bit.
- Outputs only ever change on clk edges; glitch-free.

Optional Feature:
- Macro: RESET_SEQ_PLL_LOCK_EN.
- Defined:
  - Adds input pll_locked (1 bit).
  - ~pll_locked joins src_act, and rst_cause widens to N_SRC+2 with the top bit = loss-of-lock.
  - The lock bit is set on any edge with pll_locked=0.
- Not defined:
  - No pll_locked port; rst_cause is N_SRC+1 bits; behaviour otherwise identical.

Test Plan (N_OUT=3, N_SRC=2, STRETCH_CYC=8, STAGGER_CYC=4, CNT_W=4):
- reset high for 5 cycles, then low -> rst_out=3'b111 until E0+8. Then rst_out[0]=0 at E0+8, rst_out[1]=0 at E0+12, rst_out[2]=0 and ready=1 at E0+16; rst_cause=3'b001.
- In RUN, 1-cycle pulse on rst_req[1] -> rst_out=3'b111 and ready=0 on the next edge. Full 16-cycle sequence replays; rst_cause=3'b101.
- rst_req[0] pulse at E0+10, i.e. after rst_out[0] has released -> all outputs reassert next edge. The new E0 is measured from the first quiet edge; rst_out[0] releases 8 cycles later.
- cause_clr pulse on the same edge as a rst_req[0] pulse, with prior rst_cause=3'b101 -> rst_cause=3'b010.
- reset held high for 20 cycles with cnt saturation check -> outputs stay asserted and there is no early release. rst_cause bit0 stays 1 after cause_clr while reset is high.
- RESET_SEQ_PLL_LOCK_EN defined: drop pll_locked in RUN for 1 cycle -> all rst_out reassert. rst_cause[3]=1, and the sequence restarts when lock returns.
